// File: rtl/qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qdr_port_arbiter
//  Purpose  : Round-robin write/read arbiter for a shared QDR port, with an
//             in-order tag FIFO that routes read returns back to requesters.
//  Revision : 1.0
// ============================================================================

module qdr_port_arbiter #(
  parameter int NUM_PORTS  = 24,
  parameter int ADDR_BITS  = 18,
  parameter int CTRL_WIDTH = 144,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                             fabric_clk,
  input  logic                             fabric_rst,
  input  logic [NUM_PORTS-1:0]             wr_req,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]   wr_req_addr,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0]  wr_req_data,
  output logic [NUM_PORTS-1:0]             wr_grant,
  input  logic [NUM_PORTS-1:0]             rd_req,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]   rd_req_addr,
  output logic [NUM_PORTS-1:0]             rd_grant,
  output logic [NUM_PORTS-1:0]             rd_resp_valid,
  output logic [CTRL_WIDTH-1:0]            rd_resp_data,
  output logic                             rd_orphan,
  output logic                             rd_en,
  output logic [ADDR_BITS-1:0]             rd_addr,
  input  logic                             rd_valid,
  input  logic [CTRL_WIDTH-1:0]            rd_data,
  output logic                             wr_en,
  output logic [ADDR_BITS-1:0]             wr_addr,
  output logic [CTRL_WIDTH-1:0]            wr_data
);

  localparam int C_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int C_TAG_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  // Wide enough for TAG_DEPTH held tags plus one grant still in flight.
  localparam int C_CNT_W = C_TAG_W + 2;

  // Returns {found, index} of the first requester at or above ptr, wrapping.
  function automatic logic [C_PTR_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [C_PTR_W-1:0]   ptr);
    logic               found;
    logic [C_PTR_W-1:0] win;
    int                 k;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!found && req[C_PTR_W'(k)]) begin
        found = 1'b1;
        win   = C_PTR_W'(k);
      end
    end
    return {found, win};
  endfunction

  function automatic logic [C_PTR_W-1:0] ptr_next(input logic [C_PTR_W-1:0] w);
    return (int'(w) == NUM_PORTS - 1) ? '0 : w + 1'b1;
  endfunction

  logic [C_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic                  r_wr_en, r_rd_en;
  logic [ADDR_BITS-1:0]  r_wr_addr, r_rd_addr;
  logic [CTRL_WIDTH-1:0] r_wr_data;
  logic [C_PTR_W-1:0]    r_rd_tag;
  logic [C_PTR_W-1:0]    r_tag_mem [TAG_DEPTH];
  logic [C_TAG_W-1:0]    r_tag_wptr, r_tag_rptr;
  logic [C_CNT_W-1:0]    r_count;
  logic [NUM_PORTS-1:0]  r_resp_valid;
  logic [CTRL_WIDTH-1:0] r_resp_data;
  logic                  r_orphan;

  logic                  w_wr_hit, w_rd_found, w_rd_hit, w_rd_room, w_pop;
  logic [C_PTR_W-1:0]    w_wr_win, w_rd_win, w_head;
  logic [C_CNT_W-1:0]    w_outstanding;
  logic [ADDR_BITS-1:0]  w_wr_sel_addr, w_rd_sel_addr;
  logic [CTRL_WIDTH-1:0] w_wr_sel_data;

  assign {w_wr_hit, w_wr_win}   = rr_pick(wr_req, r_wr_ptr);
  assign {w_rd_found, w_rd_win} = rr_pick(rd_req, r_rd_ptr);

  // A pop this cycle frees a slot immediately, so a stalled read can win now.
  assign w_pop         = rd_valid && (r_count != '0);
  assign w_outstanding = r_count + C_CNT_W'(r_rd_en) - C_CNT_W'(w_pop);
  assign w_rd_room     = (w_outstanding < C_CNT_W'(TAG_DEPTH));
  assign w_rd_hit      = w_rd_found && w_rd_room;
  assign w_head        = r_tag_mem[r_tag_rptr];

  always_comb begin
    wr_grant      = '0;
    rd_grant      = '0;
    w_wr_sel_addr = '0;
    w_wr_sel_data = '0;
    w_rd_sel_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_wr_win == C_PTR_W'(i)) begin
        wr_grant[i]   = w_wr_hit && !fabric_rst;
        w_wr_sel_addr = wr_req_addr[i*ADDR_BITS +: ADDR_BITS];
        w_wr_sel_data = wr_req_data[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
      if (w_rd_win == C_PTR_W'(i)) begin
        rd_grant[i]   = w_rd_hit && !fabric_rst;
        w_rd_sel_addr = rd_req_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  always_ff @(posedge fabric_clk or posedge fabric_rst) begin
    if (fabric_rst) begin
      r_wr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_ptr  <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_tag  <= '0;
    end else begin
      r_wr_en <= w_wr_hit;
      if (w_wr_hit) begin
        r_wr_ptr  <= ptr_next(w_wr_win);
        r_wr_addr <= w_wr_sel_addr;
        r_wr_data <= w_wr_sel_data;
      end
      r_rd_en <= w_rd_hit;
      if (w_rd_hit) begin
        r_rd_ptr  <= ptr_next(w_rd_win);
        r_rd_addr <= w_rd_sel_addr;
        r_rd_tag  <= w_rd_win;
      end
    end
  end

  // Tag storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge fabric_clk) begin
    if (r_rd_en) r_tag_mem[r_tag_wptr] <= r_rd_tag;
  end

  always_ff @(posedge fabric_clk or posedge fabric_rst) begin
    if (fabric_rst) begin
      r_tag_wptr   <= '0;
      r_tag_rptr   <= '0;
      r_count      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (r_rd_en) r_tag_wptr <= r_tag_wptr + 1'b1;
      if (w_pop)   r_tag_rptr <= r_tag_rptr + 1'b1;
      if (r_rd_en && !w_pop)      r_count <= r_count + C_CNT_W'(1);
      else if (!r_rd_en && w_pop) r_count <= r_count - C_CNT_W'(1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_resp_valid[i] <= w_pop && (w_head == C_PTR_W'(i));
      end
      if (w_pop) r_resp_data <= rd_data;
      r_orphan <= rd_valid && (r_count == '0);
    end
  end

  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign rd_resp_valid = r_resp_valid;
  assign rd_resp_data  = r_resp_data;
  assign rd_orphan     = r_orphan;

endmodule

`default_nettype wire

// File: tb/tb_qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qdr_port_arbiter
//  Purpose  : Directed and random checks of qdr_port_arbiter against a
//             queue-based reference model.
//  Revision : 1.0
// ============================================================================

module tb_qdr_port_arbiter;

  localparam int N  = 24;
  localparam int AB = 18;
  localparam int CW = 144;
  localparam int TD = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      wr_req, rd_req;
  logic [N*AB-1:0]   wr_req_addr, rd_req_addr;
  logic [N*CW-1:0]   wr_req_data;
  logic [N-1:0]      wr_grant, rd_grant, rd_resp_valid;
  logic [CW-1:0]     rd_resp_data, rd_data, wr_data;
  logic              rd_orphan, rd_en, rd_valid, wr_en;
  logic [AB-1:0]     rd_addr, wr_addr;

  qdr_port_arbiter #(.NUM_PORTS(N), .ADDR_BITS(AB), .CTRL_WIDTH(CW), .TAG_DEPTH(TD)) dut (
    .fabric_clk(clk), .fabric_rst(rst),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_grant(wr_grant),
    .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_grant(rd_grant),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_orphan(rd_orphan),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pointers, queue of outstanding tags, expected registered outputs.
  int          m_wr_ptr, m_rd_ptr, m_infl_tag;
  bit          m_infl;
  int          q[$];
  int          e_wg, e_rg;
  bit          e_wr_en, e_rd_en, e_orphan;
  logic [AB-1:0] e_wr_addr, e_rd_addr;
  logic [CW-1:0] e_wr_data, e_resp_data;
  logic [N-1:0]  e_resp_valid;

  logic [N-1:0] obs_wg, obs_rg;
  int           pulse_cnt [N];
  int           pulse_order[$];
  int           orph_cnt;

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int rr(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[CW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_infl = 0; m_infl_tag = 0;
    q.delete();
    e_wr_en = 0; e_rd_en = 0; e_orphan = 0;
    e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_resp_data = '0; e_resp_valid = '0;
  endtask

  task automatic compute_exp();
    int outs;
    outs = q.size() + int'(m_infl) - ((rd_valid && q.size() > 0) ? 1 : 0);
    e_wg = rst ? -1 : rr(wr_req, m_wr_ptr);
    e_rg = (rst || outs >= TD) ? -1 : rr(rd_req, m_rd_ptr);
  endtask

  task automatic model_update();
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    e_wr_en = (e_wg >= 0);
    if (e_wg >= 0) begin
      e_wr_addr = wr_req_addr[e_wg*AB +: AB];
      e_wr_data = wr_req_data[e_wg*CW +: CW];
      m_wr_ptr  = (e_wg + 1) % N;
    end
    e_rd_en = (e_rg >= 0);
    if (e_rg >= 0) begin
      e_rd_addr = rd_req_addr[e_rg*AB +: AB];
      m_rd_ptr  = (e_rg + 1) % N;
    end
    if (rd_valid && q.size() > 0) begin
      t = q.pop_front();
      e_resp_valid = oh(t);
      e_resp_data  = rd_data;
      e_orphan     = 0;
    end else begin
      e_resp_valid = '0;
      e_orphan     = rd_valid;
    end
    if (m_infl) q.push_back(m_infl_tag);
    m_infl     = (e_rg >= 0);
    m_infl_tag = e_rg;
  endtask

  // Called at posedge+1 with inputs already set; checks, then advances one clock.
  task automatic cycle();
    #1;
    compute_exp();
    obs_wg = wr_grant;
    obs_rg = rd_grant;
    chk("wr_grant", 256'(wr_grant), 256'(oh(e_wg)));
    chk("rd_grant", 256'(rd_grant), 256'(oh(e_rg)));
    chk("wr_en", 256'(wr_en), 256'(e_wr_en));
    chk("rd_en", 256'(rd_en), 256'(e_rd_en));
    if (e_wr_en || rst) begin
      chk("wr_addr", 256'(wr_addr), 256'(e_wr_addr));
      chk("wr_data", 256'(wr_data), 256'(e_wr_data));
    end
    if (e_rd_en || rst) chk("rd_addr", 256'(rd_addr), 256'(e_rd_addr));
    chk("resp_valid", 256'(rd_resp_valid), 256'(e_resp_valid));
    chk("resp_data", 256'(rd_resp_data), 256'(e_resp_data));
    chk("orphan", 256'(rd_orphan), 256'(e_orphan));
    for (int i = 0; i < N; i++) begin
      if (rd_resp_valid[i]) begin
        pulse_cnt[i]++;
        pulse_order.push_back(i);
      end
    end
    if (rd_orphan) orph_cnt++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_buses();
    for (int p = 0; p < N; p++) begin
      wr_req_addr[p*AB +: AB] = AB'($urandom);
      rd_req_addr[p*AB +: AB] = AB'($urandom);
      wr_req_data[p*CW +: CW] = rnd_data();
    end
    rd_data = rnd_data();
  endtask

  task automatic idle();
    wr_req = '0; rd_req = '0; rd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !m_infl) break;
      idle();
      rd_valid = (q.size() > 0);
      rd_data  = rnd_data();
      cycle();
    end
    rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_data = '0;
    wr_req_addr = '0; rd_req_addr = '0; wr_req_data = '0;
    model_reset();
    #1;
    @(posedge clk);
    #1;

    // Reset state: outputs and grants held low even with every port requesting.
    wr_req = '1; rd_req = '1; rd_valid = 1'b1;
    rand_buses();
    cycle();
    chk("rst_grants", 256'({wr_grant, rd_grant}), 256'(0));
    idle();
    cycle();
    rst = 1'b0;

    // Constant requests from ports 0 and 2 alternate.
    wr_req = 24'h000005;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_alt", 256'(obs_wg), 256'(oh((i % 2 == 0) ? 0 : 2)));
      if (i > 0) chk("rr_alt_wr_en", 256'(wr_en), 256'(1));
    end
    idle();
    cycle();

    // Each port reads once, starting at 23; returns arrive in grant order.
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    pulse_order.delete();
    for (int j = 0; j < N; j++) begin
      rd_req   = oh((j + 23) % N);
      rd_valid = (q.size() > 0);
      rd_data  = rnd_data();
      cycle();
      chk("rd_seq_grant", 256'(obs_rg), 256'(oh((j + 23) % N)));
    end
    drain();
    cycle();
    for (int i = 0; i < N; i++) chk("rd_seq_pulse", 256'(pulse_cnt[i]), 256'(1));
    chk("rd_seq_len", 256'(pulse_order.size()), 256'(N));
    for (int i = 0; i < pulse_order.size() && i < N; i++)
      chk("rd_seq_order", 256'(pulse_order[i]), 256'((i + 23) % N));

    // Tag exhaustion: 16 reads outstanding block the 17th until a return.
    rand_buses();
    for (int j = 0; j < TD; j++) begin
      rd_req = oh(j);
      cycle();
      chk("fill_grant", 256'(obs_rg), 256'(oh(j)));
    end
    rd_req = oh(16);
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("full_block", 256'(obs_rg), 256'(0));
    end
    rd_valid = 1'b1;
    rd_data  = rnd_data();
    cycle();
    chk("full_resume", 256'(obs_rg), 256'(oh(16)));
    drain();
    cycle();

    // Return with nothing outstanding.
    rd_valid = 1'b1;
    rd_data  = CW'(16'hABCD);
    cycle();
    rd_valid = 1'b0;
    chk("orphan_pulse", 256'({rd_orphan, rd_resp_valid}), 256'({1'b1, N'(0)}));
    chk("orphan_data_held", 256'(rd_resp_data), 256'(e_resp_data));
    cycle();
    chk("orphan_clear", 256'(rd_orphan), 256'(0));

    // Write and read issue together.
    wr_req = oh(3);
    rd_req = oh(7);
    cycle();
    chk("dual_grant", 256'({obs_wg, obs_rg}), 256'({oh(3), oh(7)}));
    idle();
    chk("dual_en", 256'({wr_en, rd_en}), 256'(2'b11));
    cycle();
    drain();
    cycle();

    // Reset with five reads outstanding; later returns are all orphans.
    for (int j = 0; j < 5; j++) begin
      rd_req = oh(j + 5);
      cycle();
    end
    idle();
    cycle();
    cycle();
    do_reset();
    orph_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      rd_valid = 1'b1;
      rd_data  = rnd_data();
      cycle();
    end
    idle();
    cycle();
    cycle();
    chk("rst_orphans", 256'(orph_cnt), 256'(5));
    wr_req = '1; rd_req = '1;
    cycle();
    chk("rst_ptr_restart", 256'({obs_wg, obs_rg}), 256'({oh(0), oh(0)}));
    idle();
    cycle();
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_buses();
      wr_req   = N'($urandom) & N'($urandom);
      rd_req   = N'($urandom) & N'($urandom);
      rd_valid = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle();
    drain();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qdr_port_arbiter.md
QDR_PORT_ARBITER -- requirements
Module: qdr_port_arbiter

Interface
REQ-001 SHALL have parameters: NUM_PORTS, default 24, number of requesting ports; ADDR_BITS, default 18, QDR address width; CTRL_WIDTH, default 144, QDR data width; TAG_DEPTH, default 16, maximum outstanding reads (power of 2).
REQ-002 SHALL have port fabric_clk, input, 1, the only clock.
REQ-003 SHALL have port fabric_rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port wr_req, input, NUM_PORTS; per-port write request, held until granted.
REQ-005 SHALL have port wr_req_addr, input, NUM_PORTS x ADDR_BITS; per-port write address.
REQ-006 SHALL have port wr_req_data, input, NUM_PORTS x CTRL_WIDTH; per-port write data.
REQ-007 SHALL have port wr_grant, output, NUM_PORTS; combinational one-hot write grant.
REQ-008 SHALL have port rd_req, input, NUM_PORTS; per-port read request.
REQ-009 SHALL have port rd_req_addr, input, NUM_PORTS x ADDR_BITS; per-port read address.
REQ-010 SHALL have port rd_grant, output, NUM_PORTS; combinational one-hot read grant.
REQ-011 SHALL have port rd_resp_valid, output, NUM_PORTS; one-hot read-return strobe.
REQ-012 SHALL have port rd_resp_data, output, CTRL_WIDTH; read-return data, broadcast to all ports.
REQ-013 SHALL have port rd_orphan, output, 1; pulses when returned data has no outstanding tag.
REQ-014 SHALL have QDR-side ports: rd_en (out, 1), rd_addr (out, ADDR_BITS), rd_valid (in, 1), rd_data (in, CTRL_WIDTH), wr_en (out, 1), wr_addr (out, ADDR_BITS), wr_data (out, CTRL_WIDTH).

Function
REQ-015 SHALL arbitrate the write and read channels independently; both may issue in the same cycle.
REQ-016 SHALL select the write winner by round robin: the lowest-index requesting port at or above wr_ptr, wrapping to 0; wr_grant is asserted for that port in the same cycle.
REQ-017 SHALL, on a write grant in cycle N, drive wr_en=1 and the winner's wr_req_addr/wr_req_data on wr_addr/wr_data in cycle N+1 (registered); otherwise wr_en=0 in N+1.
REQ-018 SHALL set wr_ptr to (winner+1) mod NUM_PORTS after each write grant; wr_ptr holds when there is no grant.
REQ-019 SHALL require a requester to drop or advance its request in cycle N+1 after a grant in cycle N; back-to-back grants to one port are permitted only when no other port requests.
REQ-020 SHALL apply REQ-016..018 identically to reads (rd_ptr, rd_grant, rd_en, rd_addr), gated by tag availability.
REQ-021 SHALL push the winner's port index into a TAG_DEPTH-entry tag FIFO in the cycle rd_en is driven.
REQ-022 SHALL suppress all read grants while the outstanding count (tags held plus a grant already in flight) equals TAG_DEPTH.
REQ-023 SHALL, on rd_valid=1 with the tag FIFO non-empty, pop the head tag and, one cycle later, assert rd_resp_valid[tag] for exactly one cycle with rd_resp_data=rd_data.
REQ-024 SHALL, on rd_valid=1 with the tag FIFO empty, assert rd_orphan for one cycle and assert no rd_resp_valid bit.
REQ-025 SHALL leave the count unchanged on a simultaneous push and pop, and SHALL wrap the FIFO pointers modulo TAG_DEPTH.
REQ-026 SHALL keep rd_resp_data stable when rd_resp_valid is 0 (last returned value held).
REQ-027 SHALL assume the QDR returns reads in issue order.

Reset
REQ-028 SHALL, while fabric_rst=1, force wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, wr_data=0, rd_resp_valid=0, rd_resp_data=0, rd_orphan=0, wr_ptr=0, rd_ptr=0, tag count=0, and wr_grant=rd_grant=0.
REQ-029 SHALL discard all outstanding tags on reset; any rd_valid arriving after reset release SHALL produce rd_orphan.

Verification
REQ-030 SHALL cover: wr_req=0x000005 held constantly -> grants alternate port 0, port 2, port 0, ...; wr_en=1 every cycle from the second cycle on, with the matching address.
REQ-031 SHALL cover: all 24 ports assert rd_req for one cycle each in turn, starting at port 23 -> grant order 23,0,1,...; tags are returned in that order; each rd_resp_valid bit pulses once.
REQ-032 SHALL cover: rd_valid withheld while 16 reads are granted -> the 17th read request receives no grant until rd_valid returns; on return, the grant resumes in the same cycle as the pop.
REQ-033 SHALL cover: rd_valid=1, rd_data=0xABCD with the tag FIFO empty -> rd_orphan=1 for one cycle and rd_resp_valid=0.
REQ-034 SHALL cover: simultaneous write grant to port 3 and read grant to port 7 in one cycle -> wr_en=1 and rd_en=1 together in the next cycle.
REQ-035 SHALL cover: fabric_rst asserted with 5 reads outstanding -> after release, 5 rd_valid pulses produce 5 rd_orphan pulses, and wr_ptr/rd_ptr restart at 0.
